// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory arbiter: read-owner state encoding
// and default geometry of the data RAM port.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_LDR = 2'd2
    } arb_state_e;

    localparam int DMEM_ADDR_W   = 14;
    localparam int DMEM_MAX_WAIT = 4;
    // Wide enough for any MAX_WAIT in 1..15
    localparam int STARVE_W      = 4;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating counter of consecutive loader refusals; sat flags that the
// loader must be forced a grant.
module dmem_starve_cnt
    import cpu_pkg::*;
#(
    parameter int MAX = DMEM_MAX_WAIT
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [STARVE_W-1:0] cnt;

    assign sat = (cnt == STARVE_W'(MAX));

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the CPU data path and the boot loader,
// with one access per cycle, read-return routing and CPU stall generation.
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ldr_mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_e state;
    logic       cpu_win;
    logic       ldr_win;
    logic       cpu_elig;
    logic       starve_sat;
    logic       cpu_rv_q;
    logic       ldr_rv_q;

    // The held cpu_req during RD_CPU belongs to the load being returned
    assign cpu_elig = cpu_req && (state != RD_CPU);

    always_comb begin
        cpu_win = 1'b0;
        ldr_win = 1'b0;
        if (!reset) begin
            if (ldr_mode) begin
                ldr_win = ldr_req;
            end else if (ldr_req && starve_sat) begin
                ldr_win = 1'b1;
            end else if (cpu_elig) begin
                cpu_win = 1'b1;
            end else begin
                ldr_win = ldr_req;
            end
        end
    end

    always_comb begin
        ram_en    = cpu_win || ldr_win;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (ldr_win) begin
            ram_we    = ldr_we;
            ram_addr  = ldr_addr;
            ram_wdata = ldr_wdata;
        end else if (cpu_win) begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end
    end

    assign ldr_gnt = ldr_win;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cpu_rv_q <= 1'b0;
            ldr_rv_q <= 1'b0;
        end else begin
            cpu_rv_q <= cpu_win && !cpu_we;
            ldr_rv_q <= ldr_win && !ldr_we;
            if (cpu_win && !cpu_we) begin
                state <= RD_CPU;
            end else if (ldr_win && !ldr_we) begin
                state <= RD_LDR;
            end else begin
                state <= IDLE;
            end
        end
    end

    // Gating with reset drops a read that was in flight when reset arrived
    assign cpu_rvalid = cpu_rv_q && !reset;
    assign ldr_rvalid = ldr_rv_q && !reset;
    assign cpu_rdata  = ram_rdata;
    assign ldr_rdata  = ram_rdata;

    assign cpu_stall = !reset && cpu_req && !cpu_rvalid && !(cpu_win && cpu_we);

    dmem_starve_cnt #(
        .MAX(MAX_WAIT)
    ) u_starve (
        .clock(clock),
        .reset(reset),
        .inc  (ldr_req && !ldr_win && !ldr_mode),
        .clr  (ldr_win || !ldr_req || ldr_mode),
        .sat  (starve_sat)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous-read RAM
// and hand-computed expectations checked by immediate assertions.
module tb_dmem_arbiter;
    import cpu_pkg::*;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic              clock;
    logic              reset;
    logic              ldr_mode;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_stall;
    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_rvalid;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int passed = 0;
    int total  = 0;

    dmem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ldr_mode  (ldr_mode),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .cpu_stall (cpu_stall),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_gnt   (ldr_gnt),
        .ldr_rdata (ldr_rdata),
        .ldr_rvalid(ldr_rvalid),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[16'h10] = 32'hDEADBEEF;
        ram_rdata = '0;

        reset = 1'b1; ldr_mode = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        tick(); tick();
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ldr_gnt", 32'(ldr_gnt), 0);
        chk("rst_cpu_stall", 32'(cpu_stall), 0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("rst_ldr_rvalid", 32'(ldr_rvalid), 0);

        // First cycle out of reset: CPU store wins over a fresh loader request
        reset = 1'b0; cpu_we = 1'b1; cpu_addr = 14'h5; cpu_wdata = 32'h55;
        ldr_addr = 14'h9;
        #1;
        chk("rel_ram_en", 32'(ram_en), 1);
        chk("rel_ldr_gnt", 32'(ldr_gnt), 0);
        chk("rel_ram_addr", 32'(ram_addr), 32'h5);
        chk("rel_store_stall", 32'(cpu_stall), 0);
        tick();

        // CPU load of 0x010
        ldr_req = 1'b0; cpu_we = 1'b0; cpu_addr = 14'h10;
        #1;
        chk("ld0_ram_en", 32'(ram_en), 1);
        chk("ld0_ram_we", 32'(ram_we), 0);
        chk("ld0_ram_addr", 32'(ram_addr), 32'h10);
        chk("ld0_stall", 32'(cpu_stall), 1);
        tick();
        chk("ld1_rvalid", 32'(cpu_rvalid), 1);
        chk("ld1_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("ld1_stall", 32'(cpu_stall), 0);
        chk("ld1_no_reissue", 32'(ram_en), 0);
        tick();

        // Continuous CPU stores versus a waiting loader write
        cpu_we = 1'b1; cpu_addr = 14'h20; cpu_wdata = 32'h1234;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 14'h30; ldr_wdata = 32'hA5A5;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("starve%0d_gnt", i), 32'(ldr_gnt), 0);
            chk($sformatf("starve%0d_addr", i), 32'(ram_addr), 32'h20);
            chk($sformatf("starve%0d_stall", i), 32'(cpu_stall), 0);
            tick();
        end
        #1;
        chk("forced_gnt", 32'(ldr_gnt), 1);
        chk("forced_stall", 32'(cpu_stall), 1);
        chk("forced_addr", 32'(ram_addr), 32'h30);
        chk("forced_we", 32'(ram_we), 1);
        tick();
        ldr_addr = 14'h31;
        #1;
        chk("restart_gnt", 32'(ldr_gnt), 0);
        chk("restart_stall", 32'(cpu_stall), 0);
        tick();
        ldr_req = 1'b0; cpu_req = 1'b0;
        tick();

        // Boot mode: loader owns the RAM, CPU held
        ldr_mode = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h10;
        ldr_req = 1'b1; ldr_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ldr_addr = 14'(i); ldr_wdata = 32'(i + 1);
            #1;
            chk($sformatf("bw%0d_gnt", i), 32'(ldr_gnt), 1);
            chk($sformatf("bw%0d_stall", i), 32'(cpu_stall), 1);
            tick();
        end
        ldr_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ldr_addr = 14'(i);
            #1;
            chk($sformatf("br%0d_gnt", i), 32'(ldr_gnt), 1);
            chk($sformatf("br%0d_stall", i), 32'(cpu_stall), 1);
            if (i > 0) begin
                chk($sformatf("br%0d_rvalid", i), 32'(ldr_rvalid), 1);
                chk($sformatf("br%0d_rdata", i), ldr_rdata, 32'(i));
            end
            tick();
        end
        ldr_req = 1'b0;
        #1;
        chk("br_last_rvalid", 32'(ldr_rvalid), 1);
        chk("br_last_rdata", ldr_rdata, 32'h8);
        chk("br_last_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("br_idle_ram_en", 32'(ram_en), 0);
        tick();

        // Loader read in flight while leaving boot mode
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 14'h3;
        #1;
        chk("tog_gnt", 32'(ldr_gnt), 1);
        tick();
        ldr_mode = 1'b0; ldr_req = 1'b0;
        #1;
        chk("tog_ldr_rvalid", 32'(ldr_rvalid), 1);
        chk("tog_ldr_rdata", ldr_rdata, 32'h4);
        chk("tog_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("tog_cpu_granted", 32'(ram_en), 1);
        chk("tog_cpu_addr", 32'(ram_addr), 32'h10);
        chk("tog_cpu_stall", 32'(cpu_stall), 1);
        tick();
        chk("tog_cpu_ret", cpu_rdata, 32'hDEADBEEF);
        chk("tog_cpu_ret_v", 32'(cpu_rvalid), 1);
        tick();

        // Reset right after a CPU read grant discards the return
        #1;
        chk("pre_rst_grant", 32'(ram_en), 1);
        tick();
        reset = 1'b1;
        #1;
        chk("rst_drop_rvalid0", 32'(cpu_rvalid), 0);
        chk("rst_drop_ram_en", 32'(ram_en), 0);
        chk("rst_drop_stall", 32'(cpu_stall), 0);
        tick();
        chk("rst_drop_rvalid1", 32'(cpu_rvalid), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_idle_grant", 32'(ram_en), 1);
        chk("post_rst_rvalid", 32'(cpu_rvalid), 0);
        tick();
        chk("post_rst_ret", 32'(cpu_rvalid), 1);
        chk("post_rst_data", cpu_rdata, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, synchronous-read data RAM between two requesters: the CPU data path (load/store via memorio) and the program/data loader (boot upload from the switch/UART side).
- Issues at most one RAM access per cycle and routes each read return to its owner.
- Stalls the single-cycle CPU while a CPU load is in flight or while the CPU is locked out.
- Sits between memorio/loader and the RAM macro, all in the core clock domain.

Parameters:
ADDR_W, 14, word-address width of the data RAM
DATA_W, 32, data word width
MAX_WAIT, 4, consecutive cycles the loader may be refused in run mode before it is forced a grant (1..15)

Ports:
clock  input  1  core clock; all state changes on its rising edge
reset  input  1  synchronous reset, active-high
ldr_mode  input  1  1 = boot/load mode, where the loader owns the RAM and the CPU is held
cpu_req  input  1  CPU data access request; held for the whole instruction
cpu_we  input  1  1 = store, 0 = load
cpu_addr  input  ADDR_W  CPU word address
cpu_wdata  input  DATA_W  CPU store data
cpu_rdata  output  DATA_W  load data; valid when cpu_rvalid=1
cpu_rvalid  output  1  load data returned this cycle
cpu_stall  output  1  hold PC/register write this cycle
ldr_req  input  1  loader access request
ldr_we  input  1  1 = write, 0 = read
ldr_addr  input  ADDR_W  loader word address
ldr_wdata  input  DATA_W  loader write data
ldr_gnt  output  1  loader access accepted this cycle
ldr_rdata  output  DATA_W  loader read data; valid when ldr_rvalid=1
ldr_rvalid  output  1  loader read data returned this cycle
ram_en  output  1  RAM access enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM address
ram_wdata  output  DATA_W  RAM write data
ram_rdata  input  DATA_W  RAM read data, one cycle after ram_en with ram_we=0

Behaviour:
- Reset:
  - Forces state IDLE and starve counter 0.
  - cpu_rvalid=ldr_rvalid=0.
  - ram_en, ram_we, ldr_gnt and cpu_stall are all 0 while reset=1.
  - A read outstanding at reset is discarded; no rvalid is returned for it.
- State (owner of the outstanding read):
  - IDLE, RD_CPU, RD_LDR.
  - Next state is RD_CPU or RD_LDR if this cycle granted a read to that owner, else IDLE.
- Grant (combinational, one winner per cycle):
  - Eligible CPU = cpu_req and not (state==RD_CPU). In RD_CPU the held cpu_req belongs to the completing load and is never re-issued.
  - ldr_mode=1: the loader wins if ldr_req; the CPU is never granted.
  - ldr_mode=0: the loader wins if ldr_req and starve==MAX_WAIT. Otherwise the eligible CPU wins. Otherwise the loader wins if ldr_req.
  - The winner drives ram_en=1 and its we/addr/wdata onto the RAM port.
  - ldr_gnt=1 exactly when the loader wins.
- Starve counter:
  - Increments when ldr_req=1 and ldr_gnt=0, saturating at MAX_WAIT.
  - Clears on ldr_gnt or ldr_req=0.
  - Held at 0 when ldr_mode=1.
- Read return:
  - cpu_rvalid is registered: 1 in the cycle after a CPU read grant. ldr_rvalid follows the same rule for the loader.
  - cpu_rdata and ldr_rdata both pass ram_rdata through. They are meaningful only when the matching rvalid=1.
  - An outstanding read completes to its original owner even if ldr_mode toggles in between.
- Pipelining: a new access may be granted in the same cycle an earlier read returns, giving full throughput of one access per cycle.
- cpu_stall (combinational) = cpu_req and not cpu_rvalid and not (CPU granted with cpu_we=1). Consequences:
  - CPU store: 1 cycle, no stall when granted.
  - CPU load: stall in the grant cycle, release in the return cycle, so 2 cycles total.
  - Refused CPU access: stalls until granted.
- Loader protocol: the loader holds req/we/addr/wdata stable until ldr_gnt, and may present a new request in the cycle after ldr_gnt.

Decomposition:
- Shared package cpu_pkg holds:
  - The state encoding: IDLE=2'd0, RD_CPU=2'd1, RD_LDR=2'd2.
  - DMEM_ADDR_W=14.
  - DMEM_MAX_WAIT=4.
- One natural sub-module, dmem_starve_cnt: a saturating counter with inc/clr/sat output.
- Everything else stays flat.

Test Plan:
- Reset held with cpu_req=ldr_req=1 -> ram_en=0, ldr_gnt=0, cpu_stall=0, both rvalid=0. Release reset; on the first cycle ram_en=1 and the CPU is granted.
- ldr_mode=0, CPU load from addr 0x010 where RAM holds 0xDEADBEEF -> cycle0: ram_en=1, we=0, cpu_stall=1. Cycle1: cpu_rvalid=1, cpu_rdata=0xDEADBEEF, cpu_stall=0, and no second RAM read is issued.
- ldr_mode=0, continuous CPU stores and ldr_req=1 -> ldr_gnt is 0 for 4 cycles and 1 on the 5th. In that cycle cpu_stall=1 and the RAM sees the loader address. The counter then restarts.
- ldr_mode=1, loader writes 0x1..0x8 to addr 0..7 back-to-back while cpu_req=1 -> ldr_gnt=1 on every cycle and cpu_stall=1 throughout. Loader reads back 0..7 with ldr_rvalid one cycle after each gnt and the data matching.
- Loader read granted, then ldr_mode drops next cycle while cpu_req=1 -> ldr_rvalid=1 with correct data and cpu_rvalid=0 in the return cycle. The CPU is granted in that same cycle.
- Reset asserted in the cycle after a CPU read grant -> cpu_rvalid=0 in that cycle and the next. State is IDLE after reset.
